// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: encode requests in, encoded RV32I words out.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [19:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [11:0] out_pc;
   logic        err;
   logic [7:0]  err_cnt;

   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, err, err_cnt
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_pc, err, err_cnt
   );
endinterface

// File: rtl/instr_encoder.sv
// Encodes simple op requests into RV32I words, queues them with their byte address,
// and counts illegal requests.
module instr_encoder #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [11:0] BASE_ADDR = 12'h000
) (
   input logic            clk,
   input logic            rst_n,
   input logic            flush,
   instr_encoder_if.slave bus
);
   localparam int unsigned    PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]    FULL    = (PW + 1)'(DEPTH);
   localparam logic [PW:0]    CNT_ONE = (PW + 1)'(1);
   localparam logic [PW-1:0]  PTR_ONE = PW'(1);

   localparam logic [6:0] OPC_R  = 7'b0110011;
   localparam logic [6:0] OPC_I  = 7'b0010011;
   localparam logic [6:0] OPC_U  = 7'b0110111;
   localparam logic [6:0] OPC_LD = 7'b0000011;
   localparam logic [6:0] OPC_ST = 7'b0100011;

   logic [31:0]   instr_mem [DEPTH];
   logic [11:0]   pc_mem    [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q;
   logic [11:0]   addr_q;
   logic          err_q;
   logic [7:0]    err_cnt_q;

   logic [31:0] enc;
   logic        legal;
   logic        accept, push, pop;

   always_comb begin
      enc   = 32'h0;
      legal = 1'b1;
      case (bus.in_op)
         4'd0:  enc = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, OPC_R};
         4'd1:  enc = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b100, bus.in_rd, OPC_R};
         4'd2:  enc = {7'b0100000, bus.in_rs2, bus.in_rs1, 3'b101, bus.in_rd, OPC_R};
         4'd3:  enc = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, OPC_I};
         4'd4:  enc = {bus.in_imm[11:0], bus.in_rs1, 3'b110, bus.in_rd, OPC_I};
         4'd5:  enc = {bus.in_imm[11:0], bus.in_rs1, 3'b111, bus.in_rd, OPC_I};
         4'd6:  enc = {7'b0100000, bus.in_imm[4:0], bus.in_rs1, 3'b101, bus.in_rd, OPC_I};
         4'd7:  enc = {bus.in_imm[19:0], bus.in_rd, OPC_U};
         4'd8:  enc = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, OPC_LD};
         4'd9:  enc = {bus.in_imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, OPC_LD};
         4'd10: enc = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b000, bus.in_imm[4:0], OPC_ST};
         4'd11: enc = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, bus.in_imm[4:0], OPC_ST};
         default: legal = 1'b0;
      endcase
   end

   // in_ready ignores a same-cycle pop: no bypass when full.
   assign bus.in_ready  = (count_q < FULL);
   assign bus.out_valid = (count_q != '0);
   assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr_q] : 32'h0;
   assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr_q] : 12'h0;
   assign bus.err       = err_q;
   assign bus.err_cnt   = err_cnt_q;

   assign accept = bus.in_valid && bus.in_ready;
   assign push   = accept && legal && !flush;
   assign pop    = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= enc;
         pc_mem[wr_ptr_q]    <= addr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         addr_q    <= BASE_ADDR;
         err_q     <= 1'b0;
         err_cnt_q <= 8'h0;
      end else if (flush) begin
         // Requests offered during a flush are dropped, including illegal ones.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= BASE_ADDR;
         err_q    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
            addr_q   <= addr_q + 12'd4;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         if (push && !pop) begin
            count_q <= count_q + CNT_ONE;
         end else if (pop && !push) begin
            count_q <= count_q - CNT_ONE;
         end
         err_q <= accept && !legal;
         if (accept && !legal && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder with a queue-based scoreboard.
module tb_instr_encoder;
   localparam int unsigned DEPTH = 4;

   logic clk    = 1'b0;
   logic rst_n  = 1'b1;
   logic flush  = 1'b0;
   logic flush2 = 1'b0;

   always #5 clk = ~clk;

   instr_encoder_if bus ();
   instr_encoder_if bus2 ();

   instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(12'h000)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave)
   );

   instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(12'hFF8)) dut2 (
      .clk(clk), .rst_n(rst_n), .flush(flush2), .bus(bus2.slave)
   );

   int checks = 0;
   int errors = 0;

   // Per-op encoding tables: format (0 R, 1 I, 2 shift-imm, 3 U, 4 S), opcode, funct3, funct7.
   int fmt_t [12] = '{0, 0, 0, 1, 1, 1, 2, 3, 1, 1, 4, 4};
   int opc_t [12] = '{'h33, 'h33, 'h33, 'h13, 'h13, 'h13, 'h13, 'h37, 'h03, 'h03, 'h23, 'h23};
   int f3_t  [12] = '{0, 4, 5, 0, 6, 7, 5, 0, 0, 2, 0, 2};
   int f7_t  [12] = '{0, 0, 'h20, 0, 0, 0, 'h20, 0, 0, 0, 0, 0};

   logic [31:0] e35 [3] = '{32'h0020A423, 32'h4020D1B3, 32'h123452B7};
   logic [11:0] e38 [3] = '{12'hFF8, 12'hFFC, 12'h000};

   typedef struct packed {
      logic [31:0] instr;
      logic [11:0] pc;
   } exp_t;

   exp_t exp_q [$];
   int   m_addr;
   int   m_errcnt;
   bit   m_err;
   int   m_sz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_encode(input int op, input logic [31:0] rd,
                                              input logic [31:0] rs1, input logic [31:0] rs2,
                                              input logic [31:0] imm);
      logic [31:0] w;
      w = 32'(opc_t[op]) | (32'(f3_t[op]) << 12);
      case (fmt_t[op])
         0: w |= (32'(f7_t[op]) << 25) | (rs2 << 20) | (rs1 << 15) | (rd << 7);
         1: w |= ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7);
         2: w |= (32'(f7_t[op]) << 25) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (rd << 7);
         3: w |= ((imm & 32'hFFFFF) << 12) | (rd << 7);
         default: w |= (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15)
                        | ((imm & 32'h1F) << 7);
      endcase
      return w;
   endfunction

   // Scoreboard: predicts acceptance from its own occupancy, checks the head every cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_addr   = 0;
         m_errcnt = 0;
         m_err    = 1'b0;
      end else begin
         m_sz = exp_q.size();
         chk("in_ready", bus.in_ready, 32'(m_sz < DEPTH));
         chk("out_valid", bus.out_valid, 32'(m_sz != 0));
         chk("err", bus.err, 32'(m_err));
         chk("err_cnt", bus.err_cnt, m_errcnt);
         if (m_sz != 0) begin
            chk("out_instr", bus.out_instr, exp_q[0].instr);
            chk("out_pc", bus.out_pc, exp_q[0].pc);
         end
         m_err = 1'b0;
         if (flush) begin
            exp_q.delete();
            m_addr = 0;
         end else begin
            if (m_sz != 0 && bus.out_ready) void'(exp_q.pop_front());
            if (bus.in_valid && m_sz < DEPTH) begin
               if (bus.in_op < 12) begin
                  exp_q.push_back('{instr: ref_encode(int'(bus.in_op), 32'(bus.in_rd),
                                                      32'(bus.in_rs1), 32'(bus.in_rs2),
                                                      32'(bus.in_imm)),
                                    pc: 12'(m_addr)});
                  m_addr = (m_addr + 4) % 4096;
               end else begin
                  m_err = 1'b1;
                  if (m_errcnt < 255) m_errcnt++;
               end
            end
         end
      end
   end

   task automatic drive(input bit v, input int op, input int rd, input int rs1, input int rs2,
                        input int imm);
      bus.in_valid = v;
      bus.in_op    = 4'(op);
      bus.in_rd    = 5'(rd);
      bus.in_rs1   = 5'(rs1);
      bus.in_rs2   = 5'(rs2);
      bus.in_imm   = 20'(imm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 1);
      chk({tag, "_out_instr"}, bus.out_instr, 0);
      chk({tag, "_out_pc"}, bus.out_pc, 0);
      chk({tag, "_err"}, bus.err, 0);
      chk({tag, "_err_cnt"}, bus.err_cnt, 0);
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      bus.out_ready  = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.in_op     = 4'd3;
      bus2.in_rd     = 5'd1;
      bus2.in_rs1    = 5'd0;
      bus2.in_rs2    = 5'd0;
      bus2.in_imm    = 20'd5;
      bus2.out_ready = 1'b1;

      // Asynchronous reset, checked before any clock edge.
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs("reset");
      repeat (2) tick();
      rst_n = 1'b1;

      // Single ADDI.
      bus.out_ready = 1'b1;
      drive(1, 3, 1, 0, 0, 5);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("addi_valid", bus.out_valid, 1);
      chk("addi_instr", bus.out_instr, 32'h00500093);
      chk("addi_pc", bus.out_pc, 12'h000);
      tick();

      // SW / SRA / LUI after a flush; unused fields set to junk.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.out_ready = 1'b0;
      drive(1, 11, 7, 1, 2, 8);
      tick();
      drive(1, 2, 3, 1, 2, 'hFFFFF);
      tick();
      drive(1, 7, 5, 9, 3, 'h12345);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("seq_instr", bus.out_instr, e35[i]);
         chk("seq_pc", bus.out_pc, 32'(i * 4));
         tick();
      end

      // Fill to full with out_ready low, then pop on a full FIFO with in_valid held.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 3, i + 1, i, 0, i * 16);
         @(negedge clk);
         chk("fill_in_ready", bus.in_ready, 32'(i < 4));
         tick();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("full_in_ready", bus.in_ready, 0);
      chk("full_out_valid", bus.out_valid, 1);
      tick();
      @(negedge clk);
      chk("after_pop_in_ready", bus.in_ready, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      repeat (6) tick();

      // Illegal ops.
      drive(1, 13, 1, 2, 3, 4);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("illegal_err", bus.err, 1);
      chk("illegal_cnt", bus.err_cnt, 1);
      chk("illegal_no_enqueue", bus.out_valid, 0);
      tick();
      @(negedge clk);
      chk("illegal_err_drop", bus.err, 0);
      tick();
      for (int i = 0; i < 300; i++) begin
         drive(1, 12 + (i % 4), i, i, i, i);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) tick();
      chk("err_cnt_sat", bus.err_cnt, 255);

      // Flush with a concurrent push, then the next push gets BASE_ADDR.
      bus.out_ready = 1'b0;
      drive(1, 3, 1, 1, 1, 1);
      tick();
      drive(1, 1, 2, 2, 2, 2);
      tick();
      drive(1, 0, 3, 3, 3, 3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("flush_out_valid", bus.out_valid, 0);
      tick();
      bus.out_ready = 1'b1;
      drive(1, 4, 6, 7, 0, 'h0F0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("flush_next_pc", bus.out_pc, 12'h000);
      chk("flush_next_valid", bus.out_valid, 1);
      tick();

      // Reset mid-stream with entries queued.
      bus.out_ready = 1'b0;
      drive(1, 5, 1, 2, 0, 'h123);
      tick();
      tick();
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("midreset");
      repeat (2) tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      drive(1, 8, 4, 5, 0, 'h7FF);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("post_reset_pc", bus.out_pc, 12'h000);
      tick();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         drive(($urandom % 4) != 0,
               (($urandom % 8) == 0) ? 12 + int'($urandom % 4) : int'($urandom % 12),
               int'($urandom), int'($urandom), int'($urandom), int'($urandom));
         bus.out_ready = ($urandom % 3) != 0;
         flush = ($urandom % 64) == 0;
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      flush = 1'b0;
      bus.out_ready = 1'b1;
      repeat (8) tick();

      // Address wrap from a non-zero base.
      bus2.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) bus2.in_valid = 1'b0;
         @(negedge clk);
         chk("wrap_valid", bus2.out_valid, 1);
         chk("wrap_pc", bus2.out_pc, e38[i]);
      end
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
